// File: rtl/wb_burst_ram.sv
// rtl/wb_burst_ram.sv - Wishbone B4 on-chip RAM slave with classic cycles and incrementing/wrapping bursts
module wb_burst_ram #(
    parameter int DATA_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int DEPTH_WORDS  = 7936,
    parameter int ADDR_WIDTH   = $clog2(DEPTH_WORDS * SELECT_WIDTH),
    parameter     INIT_FILE    = ""
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   adr_i,
    input  logic [DATA_WIDTH-1:0]   dat_i,
    output logic [DATA_WIDTH-1:0]   dat_o,
    input  logic                    we_i,
    input  logic [SELECT_WIDTH-1:0] sel_i,
    input  logic                    stb_i,
    input  logic                    cyc_i,
    input  logic [2:0]              cti_i,
    input  logic [1:0]              bte_i,
    output logic                    ack_o,
    output logic                    err_o
);

    localparam int LANE_BITS = $clog2(SELECT_WIDTH);
    localparam int WW        = ADDR_WIDTH - LANE_BITS;
    localparam logic [WW:0] DEPTH_L   = DEPTH_WORDS[WW:0];
    localparam logic [2:0]  CTI_INCR  = 3'b010;

    typedef enum logic [1:0] {IDLE, BEAT, BURST} state_t;

    state_t                  state, state_n;
    logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];
    logic [WW-1:0]           widx, widx_n, adr_widx, rd_idx;
    logic [WW:0]             mask, inc, nwidx;
    logic                    ack_n, err_n, rd_en, wr_en;
    logic [DATA_WIDTH-1:0]   wr_word;

    assign adr_widx = adr_i[ADDR_WIDTH-1:LANE_BITS];

    if (LANE_BITS > 0) begin : g_lane_bits
        logic unused_lane_bits;
        assign unused_lane_bits = ^adr_i[LANE_BITS-1:0];
    end

    always_comb begin
        mask = '0;
        case (bte_i)
            2'b01:   mask[3:0] = 4'h3;
            2'b10:   mask[3:0] = 4'h7;
            2'b11:   mask[3:0] = 4'hf;
            default: mask[3:0] = 4'h0;
        endcase
        inc = {1'b0, widx} + {{WW{1'b0}}, 1'b1};
        if (bte_i == 2'b00) nwidx = inc;
        else                nwidx = ({1'b0, widx} & ~mask) | (inc & mask);
    end

    always_comb begin
        wr_word = dat_o;
        for (int k = 0; k < SELECT_WIDTH; k++) begin
            if (sel_i[k]) wr_word[k*8 +: 8] = dat_i[k*8 +: 8];
        end
    end

    always_comb begin
        state_n = state;
        widx_n  = widx;
        ack_n   = 1'b0;
        err_n   = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = widx;
        wr_en   = 1'b0;
        if (!cyc_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (stb_i) begin
                        widx_n = adr_widx;
                        if ({1'b0, adr_widx} < DEPTH_L) begin
                            rd_en   = 1'b1;
                            rd_idx  = adr_widx;
                            ack_n   = 1'b1;
                            state_n = BEAT;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    if (stb_i) begin
                        wr_en = we_i;
                        if (cti_i == CTI_INCR) begin
                            if (nwidx < DEPTH_L) begin
                                widx_n  = nwidx[WW-1:0];
                                rd_en   = 1'b1;
                                rd_idx  = nwidx[WW-1:0];
                                ack_n   = 1'b1;
                                state_n = BURST;
                            end else begin
                                err_n = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int k = 0; k < SELECT_WIDTH; k++) begin
                if (sel_i[k]) mem[widx][k*8 +: 8] <= dat_i[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            widx  <= '0;
            ack_o <= 1'b0;
            err_o <= 1'b0;
            dat_o <= '0;
        end else begin
            state <= state_n;
            widx  <= widx_n;
            ack_o <= ack_n;
            err_o <= err_n;
            if (rd_en)      dat_o <= mem[rd_idx];
            else if (wr_en) dat_o <= wr_word;
        end
    end

endmodule

// File: tb/tb_wb_burst_ram.sv
// tb/tb_wb_burst_ram.sv - directed and randomized bench for wb_burst_ram against an array model
module tb_wb_burst_ram;
  localparam int AW    = 15;
  localparam int DEPTH = 7936;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] adr;
  logic [31:0]   dat_i, dat_o;
  logic          we, stb, cyc, ack, err;
  logic [3:0]    sel;
  logic [2:0]    cti;
  logic [1:0]    bte;

  int n_checks = 0;
  int n_fail   = 0;
  bit [31:0] model [DEPTH];
  bit        known [DEPTH];

  always #5 clk = ~clk;

  wb_burst_ram #(.DATA_WIDTH(32), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .rst(rst), .adr_i(adr), .dat_i(dat_i), .dat_o(dat_o), .we_i(we),
    .sel_i(sel), .stb_i(stb), .cyc_i(cyc), .cti_i(cti), .bte_i(bte),
    .ack_o(ack), .err_o(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] s);
    bit [31:0] r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[k*8 +: 8] = nw[k*8 +: 8];
    return r;
  endfunction

  // Next word of a burst: wrap within an aligned block of 4/8/16 words, or plain increment.
  function automatic int next_idx(input int w, input bit [1:0] b);
    int sz, base;
    if (b == 2'b00) return w + 1;
    sz   = 2 << b;
    base = w - (w % sz);
    return base + ((w + 1 - base) % sz);
  endfunction

  task automatic go_idle();
    cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000; sel = 4'h0;
  endtask

  task automatic classic(input bit w, input int idx, input bit [31:0] d, input bit [3:0] s);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = AW'(idx * 4); cti = 3'b000; bte = 2'b00;
    dat_i = d; sel = s;
    @(negedge clk);
    if (idx >= DEPTH) begin
      check("oor_err", err, 1);
      check("oor_ack", ack, 0);
      go_idle();
      @(negedge clk);
      check("oor_err_one_cycle", err, 0);
    end else begin
      check("classic_ack", ack, 1);
      check("classic_err", err, 0);
      if (known[idx]) check("classic_dat", dat_o, model[idx]);
      if (w) begin
        model[idx] = merge(model[idx], d, s);
        if (s == 4'hf) known[idx] = 1'b1;
      end
      @(negedge clk);
      check("classic_ack_low", ack, 0);
      if (known[idx]) check("classic_dat_after", dat_o, model[idx]);
      go_idle();
    end
  endtask

  task automatic burst(input bit w, input int start, input int len, input bit [1:0] b);
    int cur = start;
    int nxt;
    bit [31:0] d;
    bit [3:0] s;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; bte = b; adr = AW'(cur * 4);
    cti = (len == 1) ? 3'b111 : 3'b010; dat_i = '0; sel = 4'h0;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      check("burst_ack", ack, 1);
      check("burst_err", err, 0);
      check("burst_dat", dat_o, model[cur]);
      d = $urandom; s = 4'($urandom_range(0, 15));
      adr = AW'(cur * 4); dat_i = d; sel = s;
      cti = (i == len - 1) ? 3'b111 : 3'b010;
      if (w) model[cur] = merge(model[cur], d, s);
      if (i == len - 1) begin
        @(negedge clk);
        check("burst_end_ack", ack, 0);
        check("burst_end_err", err, 0);
        check("burst_end_dat", dat_o, model[cur]);
        go_idle();
        return;
      end
      nxt = next_idx(cur, b);
      if (nxt >= DEPTH) begin
        @(negedge clk);
        check("burst_oor_err", err, 1);
        check("burst_oor_ack", ack, 0);
        check("burst_oor_dat", dat_o, model[cur]);
        go_idle();
        @(negedge clk);
        check("burst_oor_err_low", err, 0);
        return;
      end
      cur = nxt;
    end
  endtask

  initial begin
    rst = 1'b1; adr = '0; dat_i = '0; bte = 2'b00;
    go_idle();
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_dat", dat_o, 0);
    rst = 1'b0;

    classic(1'b1, 5, 32'hA5A5_0005, 4'hf);
    classic(1'b1, 7, 32'hFFFF_FFFF, 4'hf);
    for (int i = 'h10; i <= 'h17; i++) classic(1'b1, i, $urandom, 4'hf);
    for (int i = 'h20; i <= 'h23; i++) classic(1'b1, i, $urandom, 4'hf);
    for (int i = 'h30; i <= 'h32; i++) classic(1'b1, i, $urandom, 4'hf);
    for (int i = 'h40; i <= 'h41; i++) classic(1'b1, i, $urandom, 4'hf);
    classic(1'b1, 7934, $urandom, 4'hf);
    classic(1'b1, 7935, $urandom, 4'hf);
    for (int i = 'h100; i <= 'h11f; i++) classic(1'b1, i, $urandom, 4'hf);

    classic(1'b0, 5, 32'h0, 4'h0);
    check("word5_const", dat_o, 32'hA5A5_0005);
    classic(1'b1, 7, 32'h1122_3344, 4'b0101);
    classic(1'b0, 7, 32'h0, 4'h0);
    check("word7_const", dat_o, 32'hFF22_FF44);

    burst(1'b0, 'h10, 8, 2'b00);
    burst(1'b1, 'h22, 4, 2'b01);
    for (int i = 'h20; i <= 'h23; i++) classic(1'b0, i, 32'h0, 4'h0);

    burst(1'b0, 7934, 3, 2'b00);
    classic(1'b1, 7936, 32'hDEAD_BEEF, 4'hf);
    classic(1'b0, 7935, 32'h0, 4'h0);

    // Master wait state mid-burst: the gap carries write data that must not land.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = AW'('h30 * 4); cti = 3'b010; bte = 2'b00;
    @(negedge clk);
    check("gap_beat0_dat", dat_o, model['h30]);
    @(negedge clk);
    check("gap_beat1_ack", ack, 1);
    check("gap_beat1_dat", dat_o, model['h31]);
    stb = 1'b0; we = 1'b1; dat_i = $urandom; sel = 4'hf;
    @(negedge clk);
    check("gap_ack_low", ack, 0);
    check("gap_err_low", err, 0);
    stb = 1'b1; we = 1'b0; adr = AW'('h32 * 4); cti = 3'b111;
    @(negedge clk);
    check("restart_ack", ack, 1);
    check("restart_dat", dat_o, model['h32]);
    @(negedge clk);
    check("restart_ack_low", ack, 0);
    go_idle();
    classic(1'b0, 'h31, 32'h0, 4'h0);

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = AW'('h40 * 4); cti = 3'b010; bte = 2'b00;
    @(negedge clk);
    check("rstmid_beat0_dat", dat_o, model['h40]);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ack", ack, 0);
    check("rstmid_err", err, 0);
    check("rstmid_dat", dat_o, 0);
    rst = 1'b0;
    go_idle();
    classic(1'b0, 'h41, 32'h0, 4'h0);
    classic(1'b0, 'h40, 32'h0, 4'h0);

    for (int t = 0; t < 24; t++) begin
      bit [1:0] b = 2'($urandom_range(0, 3));
      bit       w = 1'($urandom_range(0, 1));
      if (b == 2'b00) burst(w, 'h100 + $urandom_range(0, 15), $urandom_range(1, 16), b);
      else            burst(w, 'h100 + $urandom_range(0, 31), $urandom_range(1, 20), b);
    end
    for (int i = 'h100; i <= 'h11f; i++) classic(1'b0, i, 32'h0, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
